// File: rtl/onehot_decoder_seq_pkg.sv
`default_nettype none
// ============================================================================
// onehot_decoder_seq_pkg : shared state and mode encodings for the decoder
// Revision: 1.0
// ============================================================================
package onehot_decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
// onehot_dec : combinational binary to one-hot decode with channel range check
// Revision: 1.0
// ============================================================================
module onehot_dec #(
  parameter int SEL_W  = 2,
  parameter int NUM_CH = 4
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] y,
  output logic                  in_range
);

  localparam int OUT_W = 2**SEL_W;

  genvar i;
  generate
    for (i = 0; i < OUT_W; i++) begin : g_line
      assign y[i] = (sel == SEL_W'(i));
    end
  endgenerate

  // One extra bit so NUM_CH == 2**SEL_W still compares correctly
  assign in_range = ({1'b0, sel} < (SEL_W+1)'(NUM_CH));

endmodule
`default_nettype wire

// File: rtl/onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// onehot_decoder_seq : registered one-hot decoder with direct and scan modes
// Revision: 1.0
// ============================================================================
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int NUM_CH   = 4,
  parameter int STEP_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_valid,
  output logic [(2**SEL_W)-1:0] y,
  output logic                  y_valid,
  output logic [SEL_W-1:0]      cur_idx,
  output logic                  scan_wrap,
  output logic                  sel_err
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(STEP_CYC - 1);
  localparam logic [SEL_W-1:0] c_LAST_CH  = SEL_W'(NUM_CH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt;
  logic [OUT_W-1:0]   w_y;
  logic               w_y_valid;
  logic [SEL_W-1:0]   w_idx;
  logic               w_wrap;
  logic               w_err;
  logic [SEL_W-1:0]   w_scan_idx;
  logic [SEL_W-1:0]   w_dec_sel;
  logic [OUT_W-1:0]   w_dec_y;
  logic               w_in_range;

  assign w_scan_idx = (cur_idx == c_LAST_CH) ? '0 : cur_idx + 1'b1;
  // One decoder serves both modes: next scan channel while scanning, else sel
  assign w_dec_sel  = (r_state == SCAN) ? w_scan_idx : sel;

  onehot_dec #(
    .SEL_W  (SEL_W),
    .NUM_CH (NUM_CH)
  ) u_dec (
    .sel      (w_dec_sel),
    .y        (w_dec_y),
    .in_range (w_in_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      cur_idx   <= '0;
      scan_wrap <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt;
      y         <= w_y;
      y_valid   <= w_y_valid;
      cur_idx   <= w_idx;
      scan_wrap <= w_wrap;
      sel_err   <= w_err;
    end
  end

  always_comb begin
    w_next_state = IDLE;
    if (en) begin
      w_next_state = (mode == MODE_SCAN) ? SCAN : DIRECT;
    end
  end

  always_comb begin
    w_y       = y;
    w_y_valid = y_valid;
    w_idx     = cur_idx;
    w_cnt     = '0;
    w_wrap    = 1'b0;
    w_err     = 1'b0;
    case (w_next_state)
      IDLE: begin
        w_y       = '0;
        w_y_valid = 1'b0;
      end
      DIRECT: begin
        if (r_state != DIRECT) begin
          w_y       = '0;
          w_y_valid = 1'b0;
        end else if (sel_valid) begin
          if (w_in_range) begin
            w_y       = w_dec_y;
            w_y_valid = 1'b1;
            w_idx     = sel;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      SCAN: begin
        if (r_state != SCAN) begin
          w_y       = OUT_W'(1);
          w_y_valid = 1'b1;
          w_idx     = '0;
        end else if (r_cnt == c_LAST_CNT) begin
          w_y    = w_dec_y;
          w_idx  = w_scan_idx;
          w_wrap = (cur_idx == c_LAST_CH);
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_y       = '0;
        w_y_valid = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
